pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries a generic control field and data payload between two pipeline stages with a valid/ready handshake, synchronous flush (bubble insertion) and an optional 2-entry skid buffer.
- The skid buffer keeps in_ready registered and cuts the stall path.
- One instance sits between each pair of adjacent stages; the control field holds the side-effect bits (we_reg, we_dm, jal, ...), which must never assert on a bubble.

Parameters:
- CTRL_W, 8, width of control field; bits forced to 0 whenever the slot is invalid.
- DATA_W, 96, width of data payload (e.g. pc_plus4 + alu_out + rd_dm), passed unmodified.
- SKID, 1, 1 = 2-entry skid mode (registered in_ready); 0 = single-register mode (combinational in_ready).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  this stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  an entry is presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control of the presented entry; 0 when out_valid=0.
- out_data  out  DATA_W  payload of the presented entry.

Behaviour:
- Storage:
  - Main slot M: m_valid, m_ctrl, m_data.
  - Skid slot S: s_valid, s_ctrl, s_data; present only when SKID=1.
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
- Outputs:
  - out_valid = m_valid.
  - out_data = m_data.
  - out_ctrl = m_valid ? m_ctrl : 0.
- Reset (async, rst_n=0): all valid bits, ctrl and data regs = 0; out_valid=0; out_ctrl=0; out_data=0. In SKID=1, in_ready=1 from the first cycle after reset release.
- SKID=1:
  - in_ready = !s_valid (pure register output, no path from out_ready).
  - State EMPTY (m=0,s=0):
    - push -> ONE, M<=in.
  - State ONE (m=1,s=0):
    - push&pop -> ONE, M<=in.
    - push&!pop -> FULL, S<=in.
    - pop&!push -> EMPTY.
    - neither -> hold.
  - State FULL (m=1,s=1):
    - in_ready=0.
    - pop -> ONE, M<=S.
    - no pop -> hold.
  - S=1 with M=0 is illegal and unreachable.
- SKID=0:
  - in_ready = out_ready | !m_valid.
  - push -> M<=in, m_valid<=1.
  - pop&!push -> m_valid<=0.
- Latency: 1 cycle from push to out_valid when the stage is empty; entries leave strictly in push order; no entry is dropped or duplicated except by flush.
- Flush (sync, highest priority):
  - Next edge: m_valid=s_valid=0, m_ctrl=s_ctrl=0.
  - Data regs hold their values.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle completes normally downstream.
- Bubble rule: a held entry clears its ctrl to 0 when it vacates a slot (pop without refill, flush), so stale control never reappears.
- Reset asserted mid-transfer: immediate clear; in-flight entries are lost; no partial state survives.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments each cycle out_valid=1 & out_ready=0; saturates at 16'hFFFF.
  - Cleared only by rst_n; flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> out_valid=0, out_ctrl=0, out_data=0; in_ready=1 (SKID=1).
- Streaming: SKID=1, out_ready=1, push ctrl=8'h05 with data=1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each; in_ready stays 1.
- Skid fill: out_ready=0, push A=8'hAA then B=8'hBB -> after 2 edges in_ready=0, out_ctrl=8'hAA. Raise out_ready -> A pops, then B pops; in_ready returns 1 the cycle after the first pop.
- Flush with concurrent push: FULL state, flush=1 with in_valid=1, data=9 -> next cycle out_valid=0, out_ctrl=0; data 9 never appears.
- SKID=0 backpressure: out_ready=0 with M full -> in_ready=0 combinationally; out_ready=1 with push -> M replaced in the same edge, no bubble.
- PIPE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; pulse flush -> stall_cnt unchanged; rst_n low -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, sync flush, optional 2-entry skid (SKID=1).
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_buf #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // Occupancy encoding: bit 0 = main slot valid, bit 1 = skid slot valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } occ_e;

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              push;
    logic              pop;

    assign push      = in_valid & in_ready;
    assign pop       = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : '0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    generate
        if (SKID == 1) begin : g_skid
            occ_e              state;
            occ_e              state_nxt;
            logic              s_valid;
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;
            logic              m_load_in;
            logic              m_load_s;
            logic              m_drain;
            logic              s_load;
            logic              s_drain;

            // in_ready comes straight off a state flop, so out_ready never reaches it.
            assign m_valid  = state[0];
            assign s_valid  = state[1];
            assign in_ready = ~s_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= EMPTY;
                end else if (flush) begin
                    state <= EMPTY;
                end else begin
                    state <= state_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                case (state)
                    EMPTY: if (push) state_nxt = ONE;
                    ONE: begin
                        if (push && !pop)      state_nxt = FULL;
                        else if (pop && !push) state_nxt = EMPTY;
                    end
                    FULL:    if (pop) state_nxt = ONE;
                    default: state_nxt = EMPTY;
                endcase
            end

            always_comb begin
                m_load_in = 1'b0;
                m_load_s  = 1'b0;
                m_drain   = 1'b0;
                s_load    = 1'b0;
                s_drain   = 1'b0;
                case (state)
                    EMPTY: m_load_in = push;
                    ONE: begin
                        m_load_in = push & pop;
                        s_load    = push & ~pop;
                        m_drain   = pop & ~push;
                    end
                    FULL: begin
                        m_load_s = pop;
                        s_drain  = pop;
                    end
                    default: ;
                endcase
            end

            // Control bits are zeroed whenever their slot empties so a bubble never carries side effects.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_ctrl <= '0;
                    s_ctrl <= '0;
                end else if (flush) begin
                    m_ctrl <= '0;
                    s_ctrl <= '0;
                end else begin
                    if (m_load_in)     m_ctrl <= in_ctrl;
                    else if (m_load_s) m_ctrl <= s_ctrl;
                    else if (m_drain)  m_ctrl <= '0;
                    if (s_load)        s_ctrl <= in_ctrl;
                    else if (s_drain)  s_ctrl <= '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_data <= '0;
                    s_data <= '0;
                end else if (!flush) begin
                    if (m_load_in)     m_data <= in_data;
                    else if (m_load_s) m_data <= s_data;
                    if (s_load)        s_data <= in_data;
                end
            end

            a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rst_n)
                s_valid |-> m_valid);
        end else begin : g_single
            assign in_ready = out_ready | ~m_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end else if (push) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                end else if (pop) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_data <= '0;
                end else if (!flush && push) begin
                    m_data <= in_data;
                end
            end
        end
    endgenerate

`ifdef PIPE_STALL_CNT_EN
    // Survives flush on purpose: it measures downstream back-pressure, not slot contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (m_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

    a_bubble_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> (out_ctrl == '0));
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data) && $stable(out_ctrl)));

endmodule
